// File: rtl/rng_debiaser.sv
// rng_debiaser: multi-lane Von Neumann / XOR-pair / bypass entropy debiaser.
// Optional RNG_DEBIAS_STATS_EN adds the discard_cnt output.
module rng_debiaser #(
  parameter int NBITS = 256,
  parameter int NCH   = 1,
  parameter int CNTW  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [1:0]       mode,
  input  logic [CNTW-1:0]  target,
  input  logic             din_vld,
  input  logic [NCH-1:0]   din,
  output logic             busy,
  output logic             done_p,
  output logic [CNTW-1:0]  cnt,
  output logic [NBITS-1:0] y
`ifdef RNG_DEBIAS_STATS_EN
  ,
  output logic [CNTW-1:0]  discard_cnt
`endif
);

  localparam logic [CNTW-1:0] NB_C = CNTW'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNTW-1:0]  tgt_q, tgt_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             phase_q, phase_d;
  logic [NCH-1:0]   first_q, first_d;
  logic [CNTW-1:0]  acc;

  logic             is_byp, is_xor;
  logic [NCH-1:0]   pv, pb;

  assign is_byp = (mode_q == 2'b10);
  assign is_xor = (mode_q == 2'b01);

`ifdef RNG_DEBIAS_STATS_EN
  logic [CNTW-1:0]  disc_q, disc_d;
  logic [NCH-1:0]   pdisc;

  assign pdisc = (!is_byp && !is_xor && phase_q)
               ? ~(first_q ^ din) : '0;
  assign discard_cnt = disc_q;
`endif

  // Per-lane produced-bit valid/value; reserved mode falls into VN
  always_comb begin
    pv = '0;
    pb = '0;
    unique case (1'b1)
      is_byp: begin
        pv = '1;
        pb = din;
      end
      is_xor: begin
        if (phase_q) begin
          pv = '1;
          pb = first_q ^ din;
        end
      end
      default: begin
        if (phase_q) begin
          pv = first_q ^ din;
          pb = first_q;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    phase_d = phase_q;
    first_d = first_q;
    acc     = '0;
`ifdef RNG_DEBIAS_STATS_EN
    disc_d  = disc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_RUN;
          mode_d  = mode;
          tgt_d   = (target > NB_C) ? NB_C : target;
          cnt_d   = '0;
          y_d     = '0;
          phase_d = 1'b0;
          first_d = '0;
`ifdef RNG_DEBIAS_STATS_EN
          disc_d  = '0;
`endif
        end
      end
      S_RUN: begin
        if (din_vld) begin
          if (!is_byp) begin
            phase_d = ~phase_q;
            if (!phase_q) first_d = din;
          end
          // Lanes past the target limit are dropped this cycle
          for (int i = 0; i < NCH; i++) begin
            if (cnt_q + acc < tgt_q) begin
              if (pv[i]) begin
                y_d = {pb[i], y_d[NBITS-1:1]};
                acc = acc + CNTW'(1);
              end
`ifdef RNG_DEBIAS_STATS_EN
              if (pdisc[i] && disc_d != '1)
                disc_d = disc_d + CNTW'(1);
`endif
            end
          end
        end
        cnt_d = cnt_q + acc;
        if (cnt_d >= tgt_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      first_q <= '0;
`ifdef RNG_DEBIAS_STATS_EN
      disc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      first_q <= first_d;
`ifdef RNG_DEBIAS_STATS_EN
      disc_q  <= disc_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done_p = (state_q == S_DONE);
  assign cnt    = cnt_q;
  assign y      = y_q;

endmodule
